// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_WIDTH = 12;
  localparam int unsigned DMEM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic                       we;
    logic [31:0]                addr;
    logic [DMEM_DATA_WIDTH-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM: write-enable plus registered read, no reset.
module dmem_array #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: accepts one word access, inserts LATENCY wait states,
// then returns a one-cycle response while stalling the pipeline.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  stall
);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmem_req_t   req_q;

  logic                  live;
  logic                  mem_en;
  logic                  sel_we;
  logic                  sel_err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // The RAM is accessed on the edge that enters RESP so its registered read
  // data is presented during the RESP cycle. With zero wait states that edge
  // is the acceptance edge itself, so the live request feeds the RAM there.
  assign live      = (state_q == IDLE);
  assign sel_we    = live ? req_we : req_q.we;
  assign sel_addr  = live ? req_addr[ADDR_WIDTH-1:0] : req_q.addr[ADDR_WIDTH-1:0];
  assign sel_wdata = live ? req_wdata : req_q.wdata;
  assign sel_err   = live ? (|req_addr[31:ADDR_WIDTH]) : (|req_q.addr[31:ADDR_WIDTH]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d = RESP;
            mem_en  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          mem_en  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (live && req_valid) begin
        req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
      end
    end
  end

  dmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk   (clock),
    .en    (mem_en & ~sel_err),
    .we    (sel_we),
    .addr  (sel_addr),
    .wdata (sel_wdata),
    .rdata (ram_rdata)
  );

  assign req_ready  = live;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid & (|req_q.addr[31:ADDR_WIDTH]);
  assign resp_rdata = (resp_valid && !req_q.we && !resp_err) ? ram_rdata : '0;
  assign stall      = live ? req_valid : !resp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 0, 3) against a word-map model.
module tb_dmem_responder;

  localparam int NI = 3;
  localparam int unsigned LAT [NI] = '{2, 0, 3};

  logic        clock;
  logic        reset;
  logic        req_valid  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        req_ready  [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic        stall      [NI];

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mdl [int];

  int mon_out = 0;
  int mon_resp = 0;
  int mon_phantom = 0;

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      dmem_responder #(
        .ADDR_WIDTH(12),
        .DATA_WIDTH(32),
        .LATENCY   (LAT[g])
      ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid[g]),
        .req_we     (req_we[g]),
        .req_addr   (req_addr[g]),
        .req_wdata  (req_wdata[g]),
        .req_ready  (req_ready[g]),
        .resp_valid (resp_valid[g]),
        .resp_rdata (resp_rdata[g]),
        .resp_err   (resp_err[g]),
        .stall      (stall[g])
      );
    end
  endgenerate

  always #5 clock = ~clock;

  // Outstanding-access tracker for the random-mix instance.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mon_out <= 0;
    end else begin
      mon_out <= mon_out + ((req_valid[2] && req_ready[2]) ? 1 : 0)
                         - ((resp_valid[2] && mon_out > 0) ? 1 : 0);
      if (resp_valid[2]) mon_resp <= mon_resp + 1;
      if (resp_valid[2] && mon_out == 0) mon_phantom <= mon_phantom + 1;
    end
  end

  // Memory semantics: 4096 words; any address >= 4096 errors, reads 0, never writes.
  task automatic model_access(input int d, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] exp_rdata,
                              output logic exp_err, output bit known);
    int key;
    key = d * 65536 + int'(addr % 4096);
    exp_rdata = '0;
    known = 1'b1;
    exp_err = (addr >= 32'd4096);
    if (!exp_err) begin
      if (we) mdl[key] = wdata;
      else if (mdl.exists(key)) exp_rdata = mdl[key];
      else known = 1'b0;
    end
  endtask

  // Presents one request (called at a falling edge), drops req_valid right after
  // acceptance and waits a bounded time for the response.
  task automatic do_access(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input bit scramble,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int stalls, output time acc_t,
                           output bit ok);
    bit acc;
    acc = 0; lat = 0; stalls = 0; ok = 0; rdata = '0; err = 1'b0; acc_t = 0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    for (int k = 0; k < 64 && !ok; k++) begin
      #1;
      if (stall[d]) stalls++;
      if (acc) begin
        lat++;
        if (resp_valid[d]) begin
          ok = 1; rdata = resp_rdata[d]; err = resp_err[d];
        end
      end else if (req_ready[d]) begin
        @(posedge clock);
        acc_t = $time;
        #1;
        acc = 1;
        req_valid[d] = 1'b0;
        if (scramble) begin
          req_addr[d] = $urandom; req_wdata[d] = $urandom; req_we[d] = ~we;
        end
      end
      if (!ok) @(negedge clock);
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lt, st; time at; bit ok;
    #2 reset = 1'b0;
    #6;
    for (int d = 0; d < NI; d++) begin
      nvec++; if (req_ready[d] !== 1'b1) begin nerr++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
      nvec++; if (resp_valid[d] !== 1'b0) begin nerr++; $display("FAIL reset_valid[%0d]: got %b want 0", d, resp_valid[d]); end
      nvec++; if (resp_rdata[d] !== 32'h0) begin nerr++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, resp_rdata[d]); end
      nvec++; if (resp_err[d] !== 1'b0) begin nerr++; $display("FAIL reset_err[%0d]: got %b want 0", d, resp_err[d]); end
      nvec++; if (stall[d] !== 1'b0) begin nerr++; $display("FAIL reset_stall[%0d]: got %b want 0", d, stall[d]); end
    end
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    do_access(0, 1'b1, 32'd5, 32'h1111_2222, 0, rd, er, lt, st, at, ok);
    model_access(0, 1'b1, 32'd5, 32'h1111_2222, rd, er, ok);
    @(negedge clock);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'd5; req_wdata[0] = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    #3;
    nvec++; if (stall[0] !== 1'b1) begin nerr++; $display("FAIL midwait_stall: got %b want 1", stall[0]); end
    reset = 1'b0;
    #1;
    nvec++; if (req_ready[0] !== 1'b1) begin nerr++; $display("FAIL async_ready: got %b want 1", req_ready[0]); end
    nvec++; if (stall[0] !== 1'b0) begin nerr++; $display("FAIL async_stall: got %b want 0", stall[0]); end
    nvec++; if (resp_valid[0] !== 1'b0) begin nerr++; $display("FAIL async_valid: got %b want 0", resp_valid[0]); end
    @(negedge clock) reset = 1'b1;
    repeat (4) @(negedge clock);
    nvec++; if (resp_valid[0] !== 1'b0) begin nerr++; $display("FAIL dropped_resp: got %b want 0", resp_valid[0]); end
    do_access(0, 1'b0, 32'd5, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (!ok || rd !== 32'h1111_2222) begin nerr++; $display("FAIL dropped_store: got %h ok=%0d want 11112222", rd, ok); end
  endtask

  task automatic test_latency2();
    logic [31:0] rd; logic er; int lt, st; time at; bit ok;
    do_access(0, 1'b1, 32'd10, 32'h0000_1234, 0, rd, er, lt, st, at, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL l2_store_timeout: got none want resp"); end
    nvec++; if (lt !== 3) begin nerr++; $display("FAIL l2_store_lat: got %0d want 3", lt); end
    nvec++; if (st !== 3) begin nerr++; $display("FAIL l2_store_stall: got %0d want 3", st); end
    nvec++; if (rd !== 32'h0 || er !== 1'b0) begin nerr++; $display("FAIL l2_store_resp: got %h/%b want 0/0", rd, er); end
    model_access(0, 1'b1, 32'd10, 32'h0000_1234, rd, er, ok);
    do_access(0, 1'b0, 32'd10, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (lt !== 3) begin nerr++; $display("FAIL l2_load_lat: got %0d want 3", lt); end
    nvec++; if (st !== 3) begin nerr++; $display("FAIL l2_load_stall: got %0d want 3", st); end
    nvec++; if (!ok || rd !== 32'h0000_1234) begin nerr++; $display("FAIL l2_load_data: got %h want 00001234", rd); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd, r2; logic er; int lt, st; time t1, t2; bit ok;
    do_access(1, 1'b1, 32'd3, 32'd7, 0, rd, er, lt, st, t1, ok);
    do_access(1, 1'b1, 32'd4, 32'd8, 0, rd, er, lt, st, t1, ok);
    do_access(1, 1'b0, 32'd3, '0, 0, rd, er, lt, st, t1, ok);
    nvec++; if (lt !== 1) begin nerr++; $display("FAIL l0_lat: got %0d want 1", lt); end
    nvec++; if (st !== 1) begin nerr++; $display("FAIL l0_stall: got %0d want 1", st); end
    nvec++; if (!ok || rd !== 32'd7) begin nerr++; $display("FAIL l0_data: got %h want 7", rd); end
    do_access(1, 1'b0, 32'd3, '0, 0, rd, er, lt, st, t1, ok);
    do_access(1, 1'b0, 32'd4, '0, 0, r2, er, lt, st, t2, ok);
    nvec++; if (t2 - t1 !== 20) begin nerr++; $display("FAIL l0_b2b_spacing: got %0t want 20", t2 - t1); end
    nvec++; if (rd !== 32'd7 || r2 !== 32'd8) begin nerr++; $display("FAIL l0_b2b_data: got %h,%h want 7,8", rd, r2); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lt, st; time at; bit ok;
    do_access(0, 1'b1, 32'd0, 32'h0000_A5A5, 0, rd, er, lt, st, at, ok);
    model_access(0, 1'b1, 32'd0, 32'h0000_A5A5, rd, er, ok);
    do_access(0, 1'b0, 32'h0000_1000, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (!ok || er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL oor_load: got err=%b data=%h want 1/0", er, rd); end
    nvec++; if (lt !== 3) begin nerr++; $display("FAIL oor_lat: got %0d want 3", lt); end
    do_access(0, 1'b1, 32'h0000_1000, 32'd9, 0, rd, er, lt, st, at, ok);
    nvec++; if (er !== 1'b1) begin nerr++; $display("FAIL oor_store_err: got %b want 1", er); end
    do_access(0, 1'b0, 32'd0, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (rd !== 32'h0000_A5A5 || er !== 1'b0) begin nerr++; $display("FAIL oor_alias: got %h/%b want 0000a5a5/0", rd, er); end
    do_access(0, 1'b0, 32'h8000_0005, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (er !== 1'b1 || rd !== 32'h0) begin nerr++; $display("FAIL oor_msb: got err=%b data=%h want 1/0", er, rd); end
  endtask

  task automatic test_latch_hold();
    logic [31:0] rd; logic er; int lt, st, pulses; time at; bit ok;
    do_access(0, 1'b1, 32'd20, 32'h0000_5555, 1, rd, er, lt, st, at, ok);
    model_access(0, 1'b1, 32'd20, 32'h0000_5555, rd, er, ok);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock); #1;
      if (resp_valid[0]) pulses++;
    end
    nvec++; if (pulses !== 0) begin nerr++; $display("FAIL hold_extra_pulse: got %0d want 0", pulses); end
    do_access(0, 1'b0, 32'd20, '0, 1, rd, er, lt, st, at, ok);
    nvec++; if (!ok || rd !== 32'h0000_5555) begin nerr++; $display("FAIL hold_load: got %h want 00005555", rd); end
    @(negedge clock);
    do_access(0, 1'b0, 32'd20, '0, 0, rd, er, lt, st, at, ok);
    nvec++; if (rd !== 32'h0000_5555) begin nerr++; $display("FAIL hold_reload: got %h want 00005555", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, addr, wd; logic er, exp_er, we; int lt, st, r0, p0, nops; time at; bit ok, known;
    r0 = mon_resp; p0 = mon_phantom; nops = 0;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      do_access(2, 1'b1, 32'(i), wd, 0, rd, er, lt, st, at, ok);
      model_access(2, 1'b1, 32'(i), wd, exp_rd, exp_er, known);
      nops++;
    end
    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      wd = $urandom;
      do_access(2, we, addr, wd, 0, rd, er, lt, st, at, ok);
      model_access(2, we, addr, wd, exp_rd, exp_er, known);
      nops++;
      nvec++;
      if (!ok || lt !== 4 || er !== exp_er || (known && rd !== exp_rd)) begin
        nerr++;
        $display("FAIL rand[%0d] we=%b addr=%h: got ok=%0d lat=%0d err=%b data=%h want lat=4 err=%b data=%h",
                 n, we, addr, ok, lt, er, rd, exp_er, exp_rd);
      end
    end
    @(negedge clock); @(negedge clock);
    nvec++; if (mon_phantom - p0 !== 0) begin nerr++; $display("FAIL rand_phantom: got %0d want 0", mon_phantom - p0); end
    nvec++; if (mon_resp - r0 !== nops) begin nerr++; $display("FAIL rand_resp_count: got %0d want %0d", mon_resp - r0, nops); end
  endtask

  initial begin
    clock = 1'b0;
    reset = 1'b1;
    for (int d = 0; d < NI; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    test_reset();
    test_latency2();
    test_latency0();
    test_out_of_range();
    test_latch_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
